pulser_seq: RTL
===============

// Module: pulser_seq
// PURPOSE
//  Parametrised successor of the glitch pulser. Armed by the host, fires on an
//  external trigger edge, waits a delay, then emits a train of pulses whose
//  width grows by a per-pulse step (width sweep). Supports abort and auto-rearm.
//  Sits between the host config registers and the glitch output pin.
// PARAMETERS
//  DELAY_W      16  width of delay counter/input
//  WIDTH_W       8  width of pulse width, step and width accumulator
//  COUNT_W       8  width of pulse count and pulse index
//  SPACING_W    16  width of inter-pulse spacing
//  SYNC_STAGES   2  trigger synchroniser depth (>=2)
//  TRIG_EDGE     0  0 = rising edge of trigger_i, 1 = falling edge
//  OUT_POL       1  active level of pulse_o (1 = active high)
//  REARM         0  1 = return to ARMED after a completed train, 0 = to IDLE
// PORTS
//  clk              in   1          system clock
//  rst_n            in   1          asynchronous active-low reset
//  arm_i            in   1          latch config, IDLE->ARMED (ignored otherwise)
//  abort_i          in   1          cancel any activity, return to IDLE
//  trigger_i        in   1          asynchronous external trigger
//  delay_i          in   DELAY_W    cycles from trigger edge to first pulse
//  pulse_width_i    in   WIDTH_W    width of pulse 0 in cycles
//  width_step_i     in   WIDTH_W    width increment per subsequent pulse
//  num_pulses_i     in   COUNT_W    pulses per train
//  pulse_spacing_i  in   SPACING_W  inactive cycles between pulses
//  pulse_o          out  1          glitch output, registered
//  ready_o          out  1          high in IDLE
//  armed_o          out  1          high in ARMED
//  done_o           out  1          1-cycle strobe at normal train completion
//  pulse_idx_o      out  COUNT_W    index of current/last pulse
// BEHAVIOUR
//  - Reset: state IDLE; pulse_o=~OUT_POL; ready_o=1; armed_o=0; done_o=0;
//    pulse_idx_o=0; synchroniser and edge register cleared to inactive level.
//  - All outputs registered. States: IDLE, ARMED, DELAY, PULSE, SPACE.
//  - IDLE: arm_i=1 -> latch all *_i config, go ARMED. Config inputs not
//    sampled at any other time.
//  - Trigger: SYNC_STAGES flop chain, then edge register; edge detect runs in
//    every state, only acted on in ARMED. Level already active at arm does not fire.
//  - ARMED, edge detected at cycle k -> DELAY. First pulse_o active cycle is
//    k+1+D (D = latched delay; D=0 -> active at k+1).
//  - PULSE i lasts W_i cycles; W_0 = pulse_width; W_(i+1) = W_i + step,
//    saturating at 2^WIDTH_W-1. W=0 clamped to 1.
//  - SPACE between pulses lasts S cycles inactive; S=0 clamped to 1 (pulses
//    never merge). No SPACE after last pulse.
//  - pulse_idx_o = i during PULSE/SPACE of pulse i; holds last value after train.
//  - N = num_pulses. N=0: delay elapses, no pulse, done_o still strobes.
//  - Completion: cycle after last pulse ends, done_o=1 for one cycle, state ->
//    IDLE (REARM=0) or ARMED with same latched config (REARM=1).
//  - abort_i: highest priority, any state -> IDLE next cycle; pulse_o inactive
//    next cycle; no done_o; arm_i same cycle as abort ignored.
//  - arm_i in non-IDLE state ignored; triggers in DELAY/PULSE/SPACE ignored.
//  - Reset asserted mid-train: outputs return to reset values immediately.
// TESTING
//  1 D=10,W=4,N=1,S=any; arm, trigger rise at k -> pulse_o high k+11..k+14,
//    done_o at k+15, ready_o back at k+15.
//  2 D=0,W=2,step=3,N=3,S=5 -> widths 2,5,8 separated by 5 low cycles,
//    pulse_idx_o 0,1,2.
//  3 W=250,step=10,N=3 -> widths 250,255,255 (saturation).
//  4 W=0,S=0,N=2 -> two 1-cycle pulses with 1 low cycle between; N=0 ->
//    no pulse, done_o strobes after delay.
//  5 abort_i during 2nd PULSE -> pulse_o inactive next cycle, IDLE, no done_o;
//    trigger held high at arm -> no fire until low->high.
//  6 REARM=1, OUT_POL=0, TRIG_EDGE=1: two falling edges -> two identical
//    active-low trains, armed_o between; arm_i mid-train ignored.

Source files
------------

// File: rtl/pulser_seq.sv
// Armed, edge-triggered glitch pulser: after a programmable delay it emits a
// train of pulses whose width grows by a saturating step, with abort and optional rearm.
module pulser_seq #(
   parameter int DELAY_W     = 16,
   parameter int WIDTH_W     = 8,
   parameter int COUNT_W     = 8,
   parameter int SPACING_W   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TRIG_EDGE   = 0,
   parameter int OUT_POL     = 1,
   parameter int REARM       = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic                 trigger_i,
   input  logic [DELAY_W-1:0]   delay_i,
   input  logic [WIDTH_W-1:0]   pulse_width_i,
   input  logic [WIDTH_W-1:0]   width_step_i,
   input  logic [COUNT_W-1:0]   num_pulses_i,
   input  logic [SPACING_W-1:0] pulse_spacing_i,
   output logic                 pulse_o,
   output logic                 ready_o,
   output logic                 armed_o,
   output logic                 done_o,
   output logic [COUNT_W-1:0]   pulse_idx_o
);

   localparam int   DS_W      = (DELAY_W > SPACING_W) ? DELAY_W : SPACING_W;
   localparam int   TMR_W     = (DS_W > WIDTH_W) ? DS_W : WIDTH_W;
   localparam logic ACT       = (OUT_POL != 0);
   localparam logic TRIG_IDLE = (TRIG_EDGE != 0);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_SPACE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d;
   logic [DELAY_W-1:0]     cfg_delay_q, cfg_delay_d;
   logic [WIDTH_W-1:0]     cfg_width_q, cfg_width_d;
   logic [WIDTH_W-1:0]     cfg_step_q, cfg_step_d;
   logic [COUNT_W-1:0]     cfg_num_q, cfg_num_d;
   logic [SPACING_W-1:0]   cfg_space_q, cfg_space_d;
   logic [WIDTH_W-1:0]     width_q, width_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [COUNT_W-1:0]     idx_q, idx_d;
   logic                   pulse_q, pulse_d;
   logic                   ready_q, ready_d;
   logic                   armed_q, armed_d;
   logic                   done_q, done_d;

   logic                   trig_edge, start, last_pulse;
   logic [WIDTH_W:0]       width_sum;
   logic [WIDTH_W-1:0]     width_next;
   state_t                 fin_state;

   // Timer holds remaining cycles minus one; a zero width or spacing counts as one cycle.
   function automatic logic [TMR_W-1:0] len_w(input logic [WIDTH_W-1:0] w);
      return (w == '0) ? '0 : TMR_W'(w - WIDTH_W'(1));
   endfunction

   function automatic logic [TMR_W-1:0] len_s(input logic [SPACING_W-1:0] s);
      return (s == '0) ? '0 : TMR_W'(s - SPACING_W'(1));
   endfunction

   assign trig_edge  = (TRIG_EDGE == 0) ? (sync_q[SYNC_STAGES-1] & ~edge_q)
                                        : (~sync_q[SYNC_STAGES-1] & edge_q);
   assign width_sum  = {1'b0, width_q} + {1'b0, cfg_step_q};
   assign width_next = width_sum[WIDTH_W] ? '1 : width_sum[WIDTH_W-1:0];
   assign last_pulse = ({1'b0, idx_q} + (COUNT_W+1)'(1)) == {1'b0, cfg_num_q};
   assign fin_state  = (REARM != 0) ? S_ARMED : S_IDLE;

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], trigger_i};
      edge_d      = sync_q[SYNC_STAGES-1];
      state_d     = state_q;
      cfg_delay_d = cfg_delay_q;
      cfg_width_d = cfg_width_q;
      cfg_step_d  = cfg_step_q;
      cfg_num_d   = cfg_num_q;
      cfg_space_d = cfg_space_q;
      width_d     = width_q;
      timer_d     = timer_q;
      idx_d       = idx_q;
      pulse_d     = pulse_q;
      done_d      = 1'b0;
      start       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (arm_i && !abort_i) begin
               cfg_delay_d = delay_i;
               cfg_width_d = pulse_width_i;
               cfg_step_d  = width_step_i;
               cfg_num_d   = num_pulses_i;
               cfg_space_d = pulse_spacing_i;
               state_d     = S_ARMED;
            end
         end
         S_ARMED: begin
            if (trig_edge) begin
               width_d = cfg_width_q;
               idx_d   = '0;
               if (cfg_delay_q == '0) begin
                  start = 1'b1;
               end else begin
                  state_d = S_DELAY;
                  timer_d = TMR_W'(cfg_delay_q - DELAY_W'(1));
               end
            end
         end
         S_DELAY: begin
            if (timer_q == '0) start = 1'b1;
            else               timer_d = timer_q - TMR_W'(1);
         end
         S_PULSE: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TMR_W'(1);
            end else if (last_pulse) begin
               pulse_d = ~ACT;
               done_d  = 1'b1;
               state_d = fin_state;
            end else begin
               pulse_d = ~ACT;
               state_d = S_SPACE;
               timer_d = len_s(cfg_space_q);
               width_d = width_next;
            end
         end
         S_SPACE: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TMR_W'(1);
            end else begin
               pulse_d = ACT;
               state_d = S_PULSE;
               idx_d   = idx_q + COUNT_W'(1);
               timer_d = len_w(width_q);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Delay elapsed: an empty train still completes and strobes done.
      if (start) begin
         if (cfg_num_q == '0) begin
            done_d  = 1'b1;
            state_d = fin_state;
         end else begin
            pulse_d = ACT;
            state_d = S_PULSE;
            timer_d = len_w(cfg_width_q);
         end
      end

      if (abort_i) begin
         state_d = S_IDLE;
         pulse_d = ~ACT;
         done_d  = 1'b0;
      end

      ready_d = (state_d == S_IDLE);
      armed_d = (state_d == S_ARMED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sync_q      <= {SYNC_STAGES{TRIG_IDLE}};
         edge_q      <= TRIG_IDLE;
         cfg_delay_q <= '0;
         cfg_width_q <= '0;
         cfg_step_q  <= '0;
         cfg_num_q   <= '0;
         cfg_space_q <= '0;
         width_q     <= '0;
         timer_q     <= '0;
         idx_q       <= '0;
         pulse_q     <= ~ACT;
         ready_q     <= 1'b1;
         armed_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         edge_q      <= edge_d;
         cfg_delay_q <= cfg_delay_d;
         cfg_width_q <= cfg_width_d;
         cfg_step_q  <= cfg_step_d;
         cfg_num_q   <= cfg_num_d;
         cfg_space_q <= cfg_space_d;
         width_q     <= width_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         pulse_q     <= pulse_d;
         ready_q     <= ready_d;
         armed_q     <= armed_d;
         done_q      <= done_d;
      end
   end

   assign pulse_o     = pulse_q;
   assign ready_o     = ready_q;
   assign armed_o     = armed_q;
   assign done_o      = done_q;
   assign pulse_idx_o = idx_q;

endmodule
